// File: rtl/enc_bundler_pkg.sv
// Shared constants for the HV encoder bundling stage: default geometry and FSM encoding.
// Build option ENC_BUNDLER_POPCOUNT_EN (used by enc_bundler) adds the hv_popcount output.
// Geometry values here are defaults; enc_bundler exposes them as overridable parameters.
package enc_bundler_pkg;

  // Hypervector width in bits.
  localparam int HV_DIM          = 1024;
  // Feature HVs presented per input beat.
  localparam int FEATURES_PER_CC = 16;
  // Total features bundled into one sample.
  localparam int NUM_FEATURES    = 617;
  // Per-dimension counter width.
  localparam int CNT_W           = 8;
  // Minimum count for a sample_hv bit to be set.
  localparam int THRESHOLD       = 4;

  // Bundler FSM encoding.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCUM  = 2'd1;
  localparam state_t ST_THRESH = 2'd2;
  localparam state_t ST_DONE   = 2'd3;

  // Number of beats needed to carry n features at w features per beat.
  function automatic int ceil_div(input int n, input int w);
    return (n + w - 1) / w;
  endfunction

endpackage

// File: rtl/enc_bundle_counter.sv
// One dimension of the bundler: saturating counter fed by the popcount of its lane bits.
// Latency: count updates on the clock edge after add_en; hit is combinational from the count.
// No flow control: the parent decides when to clear and when to add.
module enc_bundle_counter #(
  parameter int LANES     = 2,
  parameter int CNT_W     = 8,
  parameter int THRESHOLD = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             clr,
  input  logic             add_en,
  input  logic [LANES-1:0] bits,
  output logic             hit
);

  localparam int ADD_W = $clog2(LANES + 1);
  // Sum is wide enough that cnt + addend can never overflow before the clip.
  localparam int SUM_W = CNT_W + ADD_W;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'((1 << CNT_W) - 1);

  logic [CNT_W-1:0] cnt;
  logic [ADD_W-1:0] addend;
  logic [SUM_W-1:0] sum;

  // Popcount of this dimension's (already masked) lane bits.
  always_comb begin
    addend = '0;
    for (int l = 0; l < LANES; l++) begin
      addend = addend + ADD_W'(bits[l]);
    end
  end

  // Unclipped next value; clipped below so the counter never wraps.
  always_comb begin
    sum = SUM_W'(cnt) + SUM_W'(addend);
  end

  // Counter: clear wins over add, add saturates at all-ones.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (add_en) begin
      cnt <= (sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : sum[CNT_W-1:0];
    end
  end

  assign hit = (cnt >= CNT_W'(THRESHOLD));

endmodule

// File: rtl/enc_bundler.sv
// Bundles per-feature bound HVs into one sparse sample HV via per-dimension counters.
// Latency: last beat at edge k -> THRESH during k..k+1 -> out_valid after edge k+1.
// Backpressure: sample_hv/out_valid held in DONE until out_ready. Option: ENC_BUNDLER_POPCOUNT_EN.
module enc_bundler #(
  parameter int HV_DIM          = enc_bundler_pkg::HV_DIM,
  parameter int FEATURES_PER_CC = enc_bundler_pkg::FEATURES_PER_CC,
  parameter int NUM_FEATURES    = enc_bundler_pkg::NUM_FEATURES,
  parameter int CNT_W           = enc_bundler_pkg::CNT_W,
  parameter int THRESHOLD       = enc_bundler_pkg::THRESHOLD
) (
  input  logic                              clk,
  input  logic                              nrst,
  input  logic                              start_encoding,
  input  logic                              in_valid,
  input  logic [FEATURES_PER_CC*HV_DIM-1:0] shifted_hv,
  output logic                              busy,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [HV_DIM-1:0]                 sample_hv
`ifdef ENC_BUNDLER_POPCOUNT_EN
  ,
  output logic [$clog2(HV_DIM+1)-1:0]       hv_popcount
`endif
);

  import enc_bundler_pkg::*;

  localparam int NUM_BEATS  = ceil_div(NUM_FEATURES, FEATURES_PER_CC);
  // Lanes carrying real features on the final beat; the rest are padding.
  localparam int LAST_LANES = NUM_FEATURES - (NUM_BEATS - 1) * FEATURES_PER_CC;
  localparam int BEAT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

  state_t                     state;
  logic [BEAT_W-1:0]          beat_cnt;
  logic                       last_beat;
  logic                       accept;
  logic                       clr;
  logic [FEATURES_PER_CC-1:0] lane_mask;
  logic [HV_DIM-1:0]          hits;

  assign last_beat = (beat_cnt == LAST_BEAT);
  // A start in the same cycle as a beat drops the beat.
  assign accept    = (state == ST_ACCUM) && in_valid && !start_encoding;
  // Start clears everywhere except DONE, where it only counts once the result is taken.
  assign clr       = start_encoding && ((state != ST_DONE) || out_ready);
  assign busy      = (state == ST_ACCUM) || (state == ST_THRESH);

  // Padding lanes on the last beat must not contribute to any count.
  always_comb begin
    lane_mask = '0;
    for (int l = 0; l < FEATURES_PER_CC; l++) begin
      lane_mask[l] = !last_beat || (l < LAST_LANES);
    end
  end

  for (genvar d = 0; d < HV_DIM; d++) begin : g_dim
    logic [FEATURES_PER_CC-1:0] bits;

    // Gather bit d of every lane, masking padding lanes.
    always_comb begin
      bits = '0;
      for (int l = 0; l < FEATURES_PER_CC; l++) begin
        bits[l] = shifted_hv[l*HV_DIM + d] & lane_mask[l];
      end
    end

    enc_bundle_counter #(
      .LANES     (FEATURES_PER_CC),
      .CNT_W     (CNT_W),
      .THRESHOLD (THRESHOLD)
    ) u_cnt (
      .clk    (clk),
      .nrst   (nrst),
      .clr    (clr),
      .add_en (accept),
      .bits   (bits),
      .hit    (hits[d])
    );
  end

  // Sample FSM: beat counting, threshold capture and output handshake.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= ST_IDLE;
      beat_cnt  <= '0;
      sample_hv <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_encoding) begin
            state    <= ST_ACCUM;
            beat_cnt <= '0;
          end
        end
        ST_ACCUM: begin
          if (start_encoding) begin
            beat_cnt <= '0;
          end else if (in_valid) begin
            if (last_beat) begin
              state    <= ST_THRESH;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + BEAT_W'(1);
            end
          end
        end
        ST_THRESH: begin
          if (start_encoding) begin
            state    <= ST_ACCUM;
            beat_cnt <= '0;
          end else begin
            sample_hv <= hits;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            beat_cnt  <= '0;
            state     <= start_encoding ? ST_ACCUM : ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef ENC_BUNDLER_POPCOUNT_EN
  localparam int PC_W = $clog2(HV_DIM + 1);
  logic [PC_W-1:0] hits_pc;

  // Number of set bits in the sample about to be captured.
  always_comb begin
    hits_pc = '0;
    for (int d = 0; d < HV_DIM; d++) begin
      hits_pc = hits_pc + PC_W'(hits[d]);
    end
  end

  // Popcount is captured alongside sample_hv and held with it.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hv_popcount <= '0;
    end else if ((state == ST_THRESH) && !start_encoding) begin
      hv_popcount <= hits_pc;
    end
  end
`endif

endmodule
